counter_sequencer: RTL and testbench
====================================

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameters SHALL be: DEKATRON_NUM, default 6, number of dekatron digits on the counter bus; DEKATRON_WIDTH, default 3, bits per digit; REPEAT_WIDTH, default 8, width of the step count; TIMEOUT_CYCLES, default 15, maximum WAIT cycles before abort. DW denotes DEKATRON_NUM*DEKATRON_WIDTH.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset. Ports, one per line:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous active-high reset.
- CmdValid  in  1  command offered.
- CmdReady  out  1  sequencer can accept a command.
- CmdOp  in  2  00 inc, 01 dec, 10 set, 11 reserved.
- CmdCount  in  REPEAT_WIDTH  number of inc/dec steps.
- CmdData  in  DW  load value for set.
- CmdStopOnZero  in  1  abort dec when the counter reads zero.
- CntRequest  out  1  step request to the counter.
- CntDec  out  1  decrement select.
- CntSet  out  1  load select.
- CntIn  out  DW  load value.
- CntReady  in  1  counter idle/complete.
- CntZero  in  1  counter value is zero.
- Done  out  1  one-cycle completion pulse.
- DoneSteps  out  REPEAT_WIDTH  requests completed in the last command.
- StoppedZero  out  1  last command aborted on zero.
- Timeout  out  1  last command aborted on a CntReady timeout.

Function
REQ-003 The FSM SHALL have the states IDLE, CHECK, ISSUE, GUARD, WAIT and DONE.
REQ-004 CmdReady SHALL be 1 only in IDLE; a command SHALL be accepted on an edge where CmdValid & CmdReady, latching Op, Count, Data and StopOnZero, then clearing DoneSteps, StoppedZero and Timeout and moving to CHECK.
REQ-005 CHECK SHALL branch as follows:
- op 11, or inc/dec with a remaining count of 0 -> DONE.
- dec with StopOnZero & CntZero -> DONE with StoppedZero=1.
- otherwise, if CntReady=1 -> ISSUE; if CntReady=0 -> stay in CHECK.
REQ-006 ISSUE SHALL last exactly one cycle with CntRequest=1, and CntDec, CntSet and CntIn valid in that same cycle, then move to GUARD.
REQ-007 CntDec SHALL be 1 only for op 01 and CntSet SHALL be 1 only for op 10; CntIn SHALL equal the latched Data whenever not IDLE and 0 in IDLE.
REQ-008 GUARD SHALL last one cycle and ignore CntReady, then move to WAIT.
REQ-009 In WAIT, CntReady=1 SHALL increment DoneSteps (saturating at all-ones), decrement the remaining count, and return to CHECK; set SHALL force the remaining count to 0 after its single request.
REQ-010 A WAIT cycle counter SHALL start at 0 on WAIT entry; reaching TIMEOUT_CYCLES with CntReady still 0 SHALL move to DONE with Timeout=1.
REQ-011 DONE SHALL last one cycle with Done=1 and then return to IDLE.
REQ-012 DoneSteps, StoppedZero and Timeout SHALL hold their values until the next command is accepted.
REQ-013 CntRequest SHALL never be high on two consecutive cycles.
REQ-014 The minimum step period SHALL be 4 cycles (CHECK, ISSUE, GUARD, WAIT).
REQ-015 A set command SHALL issue exactly one request regardless of CmdCount, including CmdCount=0.
REQ-016 StopOnZero SHALL be ignored for inc and set.
REQ-017 CmdValid while not IDLE SHALL be ignored, with no queueing.

Reset
REQ-018 Rst=1 SHALL asynchronously force state IDLE and CntRequest, CntDec, CntSet, CntIn, Done, DoneSteps, StoppedZero, Timeout and the internal counters to 0; CmdReady SHALL read 1 after reset.
REQ-019 Reset during ISSUE, GUARD or WAIT SHALL drop CntRequest immediately, discard the command and raise no Done pulse.
REQ-020 The first command SHALL be accepted on the first edge after Rst falls.

Verification
REQ-021 Inc, Count=3, counter model with COUNT_DELAY=3 -> three single-cycle CntRequest pulses with CntDec=0 and CntSet=0, Done pulse, DoneSteps=3, counter output +3.
REQ-022 Set, Data=0x2A, Count=5 -> one request with CntSet=1 and CntIn=0x2A, DoneSteps=1, counter output 0x2A.
REQ-023 Dec, Count=10, StopOnZero=1, counter preset to 2 -> two requests, StoppedZero=1, DoneSteps=2, counter output 0.
REQ-024 Model holds CntReady=0 after a request -> Timeout=1 and Done TIMEOUT_CYCLES+2 cycles after ISSUE, DoneSteps=0.
REQ-025 Inc with Count=0, and op 11 -> Done with no CntRequest and DoneSteps=0; CmdValid held during a busy command -> not accepted until IDLE.
REQ-026 Rst pulse mid-WAIT of a 5-step inc -> all outputs 0 asynchronously, no Done pulse, a new command is accepted on the next edge after Rst falls.

Source files
------------

// File: rtl/counter_sequencer.sv
// Step sequencer for a dekatron counter: turns inc/dec/set commands into
// one-at-a-time counter requests with zero-stop and ready-timeout aborts.
module counter_sequencer #(
  parameter int DEKATRON_NUM   = 6,
  parameter int DEKATRON_WIDTH = 3,
  parameter int REPEAT_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                                   Clk,
  input  logic                                   Rst,
  input  logic                                   CmdValid,
  output logic                                   CmdReady,
  input  logic [1:0]                             CmdOp,
  input  logic [REPEAT_WIDTH-1:0]                CmdCount,
  input  logic [DEKATRON_NUM*DEKATRON_WIDTH-1:0] CmdData,
  input  logic                                   CmdStopOnZero,
  output logic                                   CntRequest,
  output logic                                   CntDec,
  output logic                                   CntSet,
  output logic [DEKATRON_NUM*DEKATRON_WIDTH-1:0] CntIn,
  input  logic                                   CntReady,
  input  logic                                   CntZero,
  output logic                                   Done,
  output logic [REPEAT_WIDTH-1:0]                DoneSteps,
  output logic                                   StoppedZero,
  output logic                                   Timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [REPEAT_WIDTH-1:0] ONE = REPEAT_WIDTH'(1);

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state;
  logic [1:0]              op;
  logic                    stop_zero;
  logic [REPEAT_WIDTH-1:0] remaining;
  logic [TW-1:0]           wait_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= S_IDLE;
      op          <= OP_INC;
      stop_zero   <= 1'b0;
      remaining   <= '0;
      wait_cnt    <= '0;
      CmdReady    <= 1'b1;
      CntRequest  <= 1'b0;
      CntDec      <= 1'b0;
      CntSet      <= 1'b0;
      CntIn       <= '0;
      Done        <= 1'b0;
      DoneSteps   <= '0;
      StoppedZero <= 1'b0;
      Timeout     <= 1'b0;
    end else begin
      CntRequest <= 1'b0;
      Done       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (CmdValid) begin
            op          <= CmdOp;
            stop_zero   <= CmdStopOnZero;
            // set always performs exactly one request
            remaining   <= (CmdOp == OP_SET) ? ONE : CmdCount;
            CntDec      <= (CmdOp == OP_DEC);
            CntSet      <= (CmdOp == OP_SET);
            CntIn       <= CmdData;
            DoneSteps   <= '0;
            StoppedZero <= 1'b0;
            Timeout     <= 1'b0;
            CmdReady    <= 1'b0;
            state       <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (op == OP_RSV || remaining == '0) begin
            Done  <= 1'b1;
            state <= S_DONE;
          end else if (op == OP_DEC && stop_zero && CntZero) begin
            StoppedZero <= 1'b1;
            Done        <= 1'b1;
            state       <= S_DONE;
          end else if (CntReady) begin
            CntRequest <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_GUARD;
        end
        S_GUARD: begin
          // counter may still show the pre-request ready here
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (CntReady) begin
            if (DoneSteps != '1) DoneSteps <= DoneSteps + ONE;
            remaining <= (op == OP_SET) ? '0 : remaining - ONE;
            state     <= S_CHECK;
          end else if (wait_cnt == WAIT_LAST) begin
            Timeout <= 1'b1;
            Done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_DONE: begin
          CmdReady <= 1'b1;
          CntDec   <= 1'b0;
          CntSet   <= 1'b0;
          CntIn    <= '0;
          state    <= S_IDLE;
        end
        default: begin
          CmdReady <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a small delayed-counter model.
module tb_counter_sequencer;
  localparam int DW = 18;
  localparam int RW = 8;
  localparam int TO = 15;
  localparam int DLY = 3;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          CmdValid;
  logic          CmdReady;
  logic [1:0]    CmdOp;
  logic [RW-1:0] CmdCount;
  logic [DW-1:0] CmdData;
  logic          CmdStopOnZero;
  logic          CntRequest;
  logic          CntDec;
  logic          CntSet;
  logic [DW-1:0] CntIn;
  logic          CntReady;
  logic          CntZero;
  logic          Done;
  logic [RW-1:0] DoneSteps;
  logic          StoppedZero;
  logic          Timeout;

  always #5 Clk = ~Clk;

  counter_sequencer dut (
    .Clk(Clk), .Rst(Rst),
    .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdCount(CmdCount),
    .CmdData(CmdData), .CmdStopOnZero(CmdStopOnZero),
    .CntRequest(CntRequest), .CntDec(CntDec),
    .CntSet(CntSet), .CntIn(CntIn),
    .CntReady(CntReady), .CntZero(CntZero),
    .Done(Done), .DoneSteps(DoneSteps),
    .StoppedZero(StoppedZero), .Timeout(Timeout)
  );

  // counter model: busy DLY cycles per request, optional permanent stall
  logic [DW-1:0] val = '0;
  logic [DW-1:0] p_in = '0;
  logic [DW-1:0] preset_val = '0;
  logic          p_dec = 1'b0;
  logic          p_set = 1'b0;
  logic          hold = 1'b0;
  logic          stall = 1'b0;
  logic          preset_req = 1'b0;
  int            busy = 0;

  assign CntReady = (busy == 0) && !hold;
  assign CntZero  = (val == '0);

  always @(posedge Clk) begin
    if (preset_req) begin
      val  <= preset_val;
      busy <= 0;
      hold <= 1'b0;
    end else if (CntRequest) begin
      busy  <= DLY;
      p_dec <= CntDec;
      p_set <= CntSet;
      p_in  <= CntIn;
      if (stall) hold <= 1'b1;
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1)
        val <= p_set ? p_in : (p_dec ? val - 1'b1 : val + 1'b1);
    end
  end

  int            cyc = 0;
  int            req_cnt = 0;
  int            dec_cnt = 0;
  int            set_cnt = 0;
  int            done_cnt = 0;
  int            b2b = 0;
  int            last_req_cyc = 0;
  int            last_done_cyc = 0;
  logic          prev_req = 1'b0;
  logic [DW-1:0] last_in = '0;

  always @(negedge Clk) begin
    cyc++;
    if (CntRequest) begin
      req_cnt++;
      if (prev_req) b2b++;
      if (CntDec) dec_cnt++;
      if (CntSet) set_cnt++;
      last_in = CntIn;
      last_req_cyc = cyc;
    end
    prev_req = CntRequest;
    if (Done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int r0, d0, s0, e0;

  task automatic tick;
    @(negedge Clk);
    #1;
  endtask

  task automatic preset(input logic [DW-1:0] v, input logic st);
    preset_val = v;
    stall = st;
    preset_req = 1'b1;
    tick;
    preset_req = 1'b0;
  endtask

  task automatic snap;
    r0 = req_cnt;
    d0 = done_cnt;
    s0 = set_cnt;
    e0 = dec_cnt;
  endtask

  task automatic send(input logic [1:0] op, input logic [RW-1:0] cnt,
                      input logic [DW-1:0] data, input logic soz);
    int k;
    k = 0;
    while (!CmdReady && k < 50) begin
      tick;
      k++;
    end
    if (!CmdReady) begin
      n_cmp++; n_bad++;
      $display("FAIL send_ready: CmdReady=%b want 1", CmdReady);
    end
    CmdOp = op;
    CmdCount = cnt;
    CmdData = data;
    CmdStopOnZero = soz;
    CmdValid = 1'b1;
    tick;
    CmdValid = 1'b0;
  endtask

  task automatic wait_done;
    int k, d;
    d = done_cnt;
    k = 0;
    while (done_cnt == d && k < 300) begin
      tick;
      k++;
    end
    if (done_cnt == d) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done: no Done within 300 cycles");
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    CmdValid = 1'b0;
    CmdOp = 2'b00;
    CmdCount = '0;
    CmdData = '0;
    CmdStopOnZero = 1'b0;
    repeat (3) tick;
    n_cmp++; if (CmdReady !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", CmdReady); end
    n_cmp++; if (CntRequest !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", CntRequest); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", Done); end
    n_cmp++; if (DoneSteps !== 8'd0) begin n_bad++; $display("FAIL rst_steps: got %0d want 0", DoneSteps); end
    n_cmp++; if ({StoppedZero, Timeout} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b want 00", {StoppedZero, Timeout}); end
    n_cmp++; if ({CntDec, CntSet, CntIn} !== '0) begin n_bad++; $display("FAIL rst_cnt: got %b/%b/%0h want 0", CntDec, CntSet, CntIn); end
    CmdOp = 2'b11;
    CmdValid = 1'b1;
    Rst = 1'b0;
    tick;
    n_cmp++; if (CmdReady !== 1'b0) begin n_bad++; $display("FAIL rst_first_accept: CmdReady got %b want 0", CmdReady); end
    CmdValid = 1'b0;
    wait_done;
    tick;
  endtask

  task automatic test_inc;
    preset(18'd5, 1'b0);
    snap;
    send(2'b00, 8'd3, '0, 1'b0);
    wait_done;
    n_cmp++; if (req_cnt - r0 !== 3) begin n_bad++; $display("FAIL inc_reqs: got %0d want 3", req_cnt - r0); end
    n_cmp++; if ((dec_cnt - e0) + (set_cnt - s0) !== 0) begin n_bad++; $display("FAIL inc_sel: got %0d want 0", (dec_cnt - e0) + (set_cnt - s0)); end
    n_cmp++; if (DoneSteps !== 8'd3) begin n_bad++; $display("FAIL inc_steps: got %0d want 3", DoneSteps); end
    n_cmp++; if (val !== 18'd8) begin n_bad++; $display("FAIL inc_value: got %0d want 8", val); end
    tick;
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL inc_done_width: got %b want 0", Done); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL inc_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_set;
    preset(18'd7, 1'b0);
    snap;
    send(2'b10, 8'd5, 18'h2A, 1'b1);
    wait_done;
    n_cmp++; if (req_cnt - r0 !== 1) begin n_bad++; $display("FAIL set_reqs: got %0d want 1", req_cnt - r0); end
    n_cmp++; if (set_cnt - s0 !== 1) begin n_bad++; $display("FAIL set_sel: got %0d want 1", set_cnt - s0); end
    n_cmp++; if (last_in !== 18'h2A) begin n_bad++; $display("FAIL set_in: got %0h want 2a", last_in); end
    n_cmp++; if (DoneSteps !== 8'd1) begin n_bad++; $display("FAIL set_steps: got %0d want 1", DoneSteps); end
    n_cmp++; if (val !== 18'h2A) begin n_bad++; $display("FAIL set_value: got %0h want 2a", val); end
    snap;
    send(2'b10, 8'd0, 18'h15, 1'b0);
    wait_done;
    n_cmp++; if (req_cnt - r0 !== 1) begin n_bad++; $display("FAIL set0_reqs: got %0d want 1", req_cnt - r0); end
    n_cmp++; if (val !== 18'h15) begin n_bad++; $display("FAIL set0_value: got %0h want 15", val); end
  endtask

  task automatic test_dec;
    preset(18'd2, 1'b0);
    snap;
    send(2'b01, 8'd10, '0, 1'b1);
    wait_done;
    n_cmp++; if (req_cnt - r0 !== 2) begin n_bad++; $display("FAIL decz_reqs: got %0d want 2", req_cnt - r0); end
    n_cmp++; if (dec_cnt - e0 !== 2) begin n_bad++; $display("FAIL decz_sel: got %0d want 2", dec_cnt - e0); end
    n_cmp++; if (StoppedZero !== 1'b1) begin n_bad++; $display("FAIL decz_stop: got %b want 1", StoppedZero); end
    n_cmp++; if (DoneSteps !== 8'd2) begin n_bad++; $display("FAIL decz_steps: got %0d want 2", DoneSteps); end
    n_cmp++; if (val !== 18'd0) begin n_bad++; $display("FAIL decz_value: got %0d want 0", val); end
    preset(18'd4, 1'b0);
    send(2'b01, 8'd2, '0, 1'b0);
    wait_done;
    n_cmp++; if (val !== 18'd2) begin n_bad++; $display("FAIL dec_value: got %0d want 2", val); end
    n_cmp++; if (StoppedZero !== 1'b0) begin n_bad++; $display("FAIL dec_stop: got %b want 0", StoppedZero); end
    preset(18'd0, 1'b0);
    snap;
    send(2'b00, 8'd1, '0, 1'b1);
    wait_done;
    n_cmp++; if (req_cnt - r0 !== 1) begin n_bad++; $display("FAIL incz_reqs: got %0d want 1", req_cnt - r0); end
    n_cmp++; if ({StoppedZero, val} !== {1'b0, 18'd1}) begin n_bad++; $display("FAIL incz_result: got %b/%0d want 0/1", StoppedZero, val); end
  endtask

  task automatic test_timeout;
    preset(18'd0, 1'b1);
    snap;
    send(2'b00, 8'd2, '0, 1'b0);
    wait_done;
    n_cmp++; if (Timeout !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b want 1", Timeout); end
    n_cmp++; if (DoneSteps !== 8'd0) begin n_bad++; $display("FAIL to_steps: got %0d want 0", DoneSteps); end
    n_cmp++; if (req_cnt - r0 !== 1) begin n_bad++; $display("FAIL to_reqs: got %0d want 1", req_cnt - r0); end
    n_cmp++; if (last_done_cyc - last_req_cyc !== TO + 2) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", last_done_cyc - last_req_cyc, TO + 2); end
    tick;
    n_cmp++; if (Timeout !== 1'b1) begin n_bad++; $display("FAIL to_hold: got %b want 1", Timeout); end
    preset(18'd0, 1'b0);
  endtask

  task automatic test_zero_reserved;
    snap;
    send(2'b00, 8'd0, '0, 1'b0);
    wait_done;
    n_cmp++; if (req_cnt - r0 !== 0) begin n_bad++; $display("FAIL cnt0_reqs: got %0d want 0", req_cnt - r0); end
    n_cmp++; if ({DoneSteps, Timeout} !== 9'd0) begin n_bad++; $display("FAIL cnt0_status: got %0d/%b want 0/0", DoneSteps, Timeout); end
    snap;
    send(2'b11, 8'd4, 18'h3, 1'b0);
    wait_done;
    n_cmp++; if (req_cnt - r0 !== 0) begin n_bad++; $display("FAIL rsv_reqs: got %0d want 0", req_cnt - r0); end
    n_cmp++; if (DoneSteps !== 8'd0) begin n_bad++; $display("FAIL rsv_steps: got %0d want 0", DoneSteps); end
  endtask

  task automatic test_back_to_back;
    preset(18'd0, 1'b0);
    snap;
    CmdOp = 2'b00;
    CmdCount = 8'd2;
    CmdData = '0;
    CmdStopOnZero = 1'b0;
    CmdValid = 1'b1;
    tick;
    CmdOp = 2'b10;
    CmdData = 18'h11;
    CmdCount = 8'd0;
    wait_done;
    n_cmp++; if (DoneSteps !== 8'd2) begin n_bad++; $display("FAIL busy_steps: got %0d want 2", DoneSteps); end
    n_cmp++; if (set_cnt - s0 !== 0) begin n_bad++; $display("FAIL busy_ignored: got %0d want 0", set_cnt - s0); end
    n_cmp++; if (val !== 18'd2) begin n_bad++; $display("FAIL busy_value: got %0d want 2", val); end
    tick;
    n_cmp++; if (CmdReady !== 1'b1) begin n_bad++; $display("FAIL busy_idle: got %b want 1", CmdReady); end
    tick;
    n_cmp++; if (CmdReady !== 1'b0) begin n_bad++; $display("FAIL busy_accept: got %b want 0", CmdReady); end
    CmdValid = 1'b0;
    wait_done;
    n_cmp++; if ({DoneSteps, val} !== {8'd1, 18'h11}) begin n_bad++; $display("FAIL busy_second: got %0d/%0h want 1/11", DoneSteps, val); end
  endtask

  task automatic test_reset_mid;
    int k;
    preset(18'd0, 1'b0);
    snap;
    send(2'b00, 8'd5, 18'h155, 1'b0);
    k = 0;
    while (req_cnt - r0 < 2 && k < 100) begin tick; k++; end
    tick;
    tick;
    n_cmp++; if ({CntIn, DoneSteps} !== {18'h155, 8'd1}) begin n_bad++; $display("FAIL mid_pre: got %0h/%0d want 155/1", CntIn, DoneSteps); end
    #2 Rst = 1'b1;
    #1;
    n_cmp++; if ({CntIn, DoneSteps} !== '0) begin n_bad++; $display("FAIL mid_async: got %0h/%0d want 0/0", CntIn, DoneSteps); end
    n_cmp++; if (CmdReady !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", CmdReady); end
    tick;
    tick;
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - d0); end
    CmdOp = 2'b11;
    CmdValid = 1'b1;
    Rst = 1'b0;
    tick;
    n_cmp++; if (CmdReady !== 1'b0) begin n_bad++; $display("FAIL mid_accept: got %b want 0", CmdReady); end
    CmdValid = 1'b0;
    wait_done;
    snap;
    send(2'b00, 8'd3, '0, 1'b0);
    k = 0;
    while (!CntRequest && k < 50) begin tick; k++; end
    Rst = 1'b1;
    #1;
    n_cmp++; if (CntRequest !== 1'b0) begin n_bad++; $display("FAIL issue_async: got %b want 0", CntRequest); end
    tick;
    Rst = 1'b0;
    tick;
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL issue_no_done: got %0d want 0", done_cnt - d0); end
  endtask

  initial begin
    test_reset;
    test_inc;
    test_set;
    test_dec;
    test_timeout;
    test_zero_reserved;
    test_back_to_back;
    test_reset_mid;
    n_cmp++; if (b2b !== 0) begin n_bad++; $display("FAIL req_consecutive: got %0d want 0", b2b); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
